// File: rtl/vliw_fetch_queue.sv
// Instruction-bundle queue between instruction memory and the IF/ID register.
// Circular buffer with a first-word-fall-through head; flush squashes everything queued.
module vliw_fetch_queue #(
  parameter int BUNDLE_W = 48,
  parameter int DEPTH    = 4,
  parameter int PC_W     = 32,
  parameter int PC_INC   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetchValid,
  input  logic [PC_W-1:0]          fetchPC,
  input  logic [BUNDLE_W-1:0]      fetchBundle,
  output logic                     fetchReady,
  input  logic                     flush,
  input  logic                     issueStall,
  output logic                     issueValid,
  output logic [PC_W-1:0]          issuePC,
  output logic [PC_W-1:0]          issuePCPlus,
  output logic [BUNDLE_W-1:0]      issueBundle,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [PC_W-1:0]     pc;
    logic [BUNDLE_W-1:0] bundle;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   rdptr, wrptr;
  logic [CW-1:0]   cnt;
  logic [PC_W-1:0] last_pc;
  logic            push, pop;

  assign fetchReady  = (cnt < CW'(DEPTH));
  assign issueValid  = (cnt != '0);
  assign count       = cnt;
  assign push        = fetchValid & fetchReady & ~flush;
  assign pop         = issueValid & ~issueStall & ~flush;

  // Empty queue keeps showing the last issued PC so decode sees a stable value.
  assign head        = mem[rdptr];
  assign issuePC     = issueValid ? head.pc : last_pc;
  assign issuePCPlus = issuePC + PC_W'(PC_INC);
  assign issueBundle = issueValid ? head.bundle : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdptr   <= '0;
      wrptr   <= '0;
      cnt     <= '0;
      last_pc <= '0;
    end else begin
      if (issueValid) last_pc <= head.pc;
      if (flush) begin
        rdptr <= wrptr;
        cnt   <= '0;
      end else begin
        // DEPTH is a power of two, so pointers wrap by natural overflow.
        if (push) wrptr <= wrptr + 1'b1;
        if (pop)  rdptr <= rdptr + 1'b1;
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrptr] <= '{pc: fetchPC, bundle: fetchBundle};
  end

endmodule

// File: tb/tb_vliw_fetch_queue.sv
// Self-checking bench for vliw_fetch_queue: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_vliw_fetch_queue;
  localparam int BW = 48, DEPTH = 4, PW = 32, INC = 4;

  logic          clk, reset;
  logic          fetchValid, flush, issueStall;
  logic [PW-1:0] fetchPC;
  logic [BW-1:0] fetchBundle;
  logic          fetchReady, issueValid;
  logic [PW-1:0] issuePC, issuePCPlus;
  logic [BW-1:0] issueBundle;
  logic [2:0]    count;

  int tests = 0, fails = 0;

  vliw_fetch_queue #(.BUNDLE_W(BW), .DEPTH(DEPTH), .PC_W(PW), .PC_INC(INC)) dut (
    .clk(clk), .reset(reset), .fetchValid(fetchValid), .fetchPC(fetchPC),
    .fetchBundle(fetchBundle), .fetchReady(fetchReady), .flush(flush),
    .issueStall(issueStall), .issueValid(issueValid), .issuePC(issuePC),
    .issuePCPlus(issuePCPlus), .issueBundle(issueBundle), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic [PW-1:0] pc, input logic [BW-1:0] b,
                       input logic fl, input logic st);
    fetchValid = fv; fetchPC = pc; fetchBundle = b; flush = fl; issueStall = st;
  endtask

  task automatic chk_head(input string nm, input logic v, input logic [PW-1:0] pc,
                          input logic [BW-1:0] b, input int c, input logic rdy);
    chk({nm, ".valid"}, 64'(issueValid), 64'(v));
    chk({nm, ".pc"}, 64'(issuePC), 64'(pc));
    chk({nm, ".pcplus"}, 64'(issuePCPlus), 64'(PW'(pc + INC)));
    chk({nm, ".bundle"}, 64'(issueBundle), 64'(b));
    chk({nm, ".count"}, 64'(count), 64'(c));
    chk({nm, ".ready"}, 64'(fetchReady), 64'(rdy));
  endtask

  typedef struct {
    logic          fv;
    logic [PW-1:0] pc;
    logic [BW-1:0] b;
    logic          fl, st;
    logic          e_v;
    logic [PW-1:0] e_pc;
    logic [BW-1:0] e_b;
    int            e_c;
    logic          e_rdy;
  } vec_t;

  typedef struct {
    logic [PW-1:0] pc;
    logic [BW-1:0] b;
  } ent_t;

  vec_t vt[14];
  ent_t mq[$];
  logic [PW-1:0] m_last;

  initial begin
    // pass-through, fill under stall, full retry, drain, PC wrap for issuePCPlus
    vt[0]  = '{1, 'h100, 48'hABCD12345678, 0, 0, 1, 'h100, 48'hABCD12345678, 1, 1};
    vt[1]  = '{0, 0, 0, 0, 0,                  0, 'h100, 0, 0, 1};
    vt[2]  = '{1, 'h0, 1, 0, 1,                1, 'h0, 1, 1, 1};
    vt[3]  = '{1, 'h4, 2, 0, 1,                1, 'h0, 1, 2, 1};
    vt[4]  = '{1, 'h8, 3, 0, 1,                1, 'h0, 1, 3, 1};
    vt[5]  = '{1, 'hC, 4, 0, 1,                1, 'h0, 1, 4, 0};
    vt[6]  = '{1, 'h10, 5, 0, 1,               1, 'h0, 1, 4, 0};
    vt[7]  = '{1, 'h10, 5, 0, 0,               1, 'h4, 2, 3, 1};
    vt[8]  = '{1, 'h10, 5, 0, 0,               1, 'h8, 3, 3, 1};
    vt[9]  = '{0, 0, 0, 0, 0,                  1, 'hC, 4, 2, 1};
    vt[10] = '{0, 0, 0, 0, 0,                  1, 'h10, 5, 1, 1};
    vt[11] = '{0, 0, 0, 0, 0,                  0, 'h10, 0, 0, 1};
    vt[12] = '{1, 'hFFFF_FFFC, 6, 0, 1,        1, 'hFFFF_FFFC, 6, 1, 1};
    vt[13] = '{0, 0, 0, 0, 0,                  0, 'hFFFF_FFFC, 0, 0, 1};

    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_head("reset", 0, 0, 0, 0, 1);

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].fv, vt[i].pc, vt[i].b, vt[i].fl, vt[i].st);
      cyc();
      chk_head($sformatf("vec%0d", i), vt[i].e_v, vt[i].e_pc, vt[i].e_b, vt[i].e_c, vt[i].e_rdy);
    end

    // steady push+pop at count 2, pointers wrap several times
    drive(1, 'h200, 'h200, 0, 1); cyc();
    drive(1, 'h204, 'h204, 0, 1); cyc();
    for (int k = 0; k < 10; k++) begin
      drive(1, PW'('h208 + 4 * k), BW'('h208 + 4 * k), 0, 0);
      cyc();
      chk($sformatf("pp%0d.count", k), 64'(count), 64'd2);
      chk($sformatf("pp%0d.pc", k), 64'(issuePC), 64'('h204 + 4 * k));
      chk($sformatf("pp%0d.bundle", k), 64'(issueBundle), 64'('h204 + 4 * k));
    end

    // flush with count 3 and an incoming bundle that must be dropped
    drive(1, 'h20, 'h20, 1, 1); cyc();
    chk("flush0.count", 64'(count), 64'd0);
    drive(1, 'h20, 'h20, 0, 1); cyc();
    drive(1, 'h24, 'h24, 0, 1); cyc();
    drive(1, 'h28, 'h28, 0, 1); cyc();
    chk("preflush.count", 64'(count), 64'd3);
    drive(1, 'h40, 'h40, 1, 1); cyc();
    chk_head("flush", 0, 'h20, 0, 0, 1);
    drive(0, 0, 0, 0, 0); cyc();
    chk("flush.idle", 64'(count), 64'd0);
    drive(1, 'h80, 'h80, 0, 0); cyc();
    chk_head("afterflush", 1, 'h80, 'h80, 1, 1);
    drive(1, 'h84, 'h84, 1, 0); cyc();
    chk("b2b_flush1", 64'(count), 64'd0);
    drive(1, 'h88, 'h88, 1, 0); cyc();
    chk("b2b_flush2", 64'(count), 64'd0);

    // async reset between edges
    drive(1, 'h90, 'h90, 0, 1); cyc();
    drive(1, 'h94, 'h94, 0, 1); cyc();
    drive(1, 'h98, 'h98, 0, 1); cyc();
    drive(0, 0, 0, 0, 1);
    #2 reset = 1'b0;
    #1 chk_head("async_rst", 0, 0, 0, 0, 1);
    @(negedge clk) reset = 1'b1;
    drive(1, 'h300, 48'h1234, 0, 0); cyc();
    chk_head("post_rst", 1, 'h300, 48'h1234, 1, 1);

    // randomized traffic vs reference model, from a clean reset
    drive(0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    #1;
    mq.delete();
    m_last = '0;
    for (int n = 0; n < 500; n++) begin
      logic          mv, mr, fv, fl, st;
      logic [PW-1:0] pc;
      logic [BW-1:0] b;
      mv = (mq.size() != 0);
      mr = (mq.size() < DEPTH);
      chk("rnd.count", 64'(count), 64'(mq.size()));
      chk("rnd.ready", 64'(fetchReady), 64'(mr));
      chk("rnd.valid", 64'(issueValid), 64'(mv));
      chk("rnd.pc", 64'(issuePC), 64'(mv ? mq[0].pc : m_last));
      chk("rnd.pcplus", 64'(issuePCPlus), 64'(PW'((mv ? mq[0].pc : m_last) + INC)));
      chk("rnd.bundle", 64'(issueBundle), 64'(mv ? mq[0].b : '0));
      fv = ($urandom_range(0, 3) != 0);
      pc = $urandom;
      b  = {16'($urandom), 32'($urandom)};
      st = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 15) == 0);
      drive(fv, pc, b, fl, st);
      if (mv) m_last = mq[0].pc;
      if (fl) mq.delete();
      else begin
        if (mv && !st) void'(mq.pop_front());
        if (fv && mr) mq.push_back('{pc: pc, b: b});
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
